// File: rtl/cache_requester.sv
// CPU-side initiator for the 2-entry CLOCK cache.
// One load/store at a time; read misses fill from memory, stores write through.
module cache_requester #(
    parameter int ADDR_WIDTH    = 8,
    parameter int LINE_WIDTH    = 32,
    parameter int WRITE_TIMEOUT = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [LINE_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] c_addr,
    output logic [LINE_WIDTH-1:0] c_val,
    output logic                  c_read,
    output logic                  c_write,
    input  logic                  c_hit,
    input  logic [LINE_WIDTH-1:0] c_out_val,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [LINE_WIDTH-1:0] mem_rdata
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] R_ISSUE = 3'd1;
    localparam logic [2:0] R_CHECK = 3'd2;
    localparam logic [2:0] M_REQ   = 3'd3;
    localparam logic [2:0] W_ISSUE = 3'd4;
    localparam logic [2:0] W_HOLD  = 3'd5;
    localparam logic [2:0] RESP    = 3'd6;

    localparam int TW = $clog2(WRITE_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(WRITE_TIMEOUT - 1);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] val_q;
    logic [LINE_WIDTH-1:0] data_q;
    logic                  fill_q;
    logic                  we_q;
    logic                  err_q;
    logic [TW-1:0]         timer;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= '0;
            val_q  <= '0;
            data_q <= '0;
            fill_q <= 1'b0;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            timer  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        val_q  <= req_wdata;
                        data_q <= '0;
                        fill_q <= 1'b0;
                        we_q   <= 1'b0;
                        err_q  <= 1'b0;
                        state  <= req_write ? W_ISSUE : R_ISSUE;
                    end
                end
                R_ISSUE: state <= R_CHECK;
                R_CHECK: begin
                    if (c_hit) begin
                        data_q <= c_out_val;
                        state  <= RESP;
                    end else begin
                        we_q  <= 1'b0;
                        state <= M_REQ;
                    end
                end
                M_REQ: begin
                    if (mem_ack) begin
                        if (we_q) begin
                            state <= RESP;
                        end else begin
                            // fetched line becomes both the fill value and the reply
                            val_q  <= mem_rdata;
                            data_q <= mem_rdata;
                            fill_q <= 1'b1;
                            state  <= W_ISSUE;
                        end
                    end
                end
                W_ISSUE: begin
                    timer <= '0;
                    state <= W_HOLD;
                end
                W_HOLD: begin
                    if (c_hit) begin
                        if (fill_q) begin
                            state <= RESP;
                        end else begin
                            we_q  <= 1'b1;
                            state <= M_REQ;
                        end
                    end else if (timer == T_LAST) begin
                        err_q  <= 1'b1;
                        data_q <= '0;
                        state  <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_data  = rsp_valid ? data_q : '0;
    assign rsp_err   = rsp_valid & err_q;

    assign c_addr  = addr_q;
    assign c_val   = val_q;
    assign c_read  = (state == R_ISSUE);
    // keep the write strobe up while the cache evicts, drop it on hit
    assign c_write = (state == W_ISSUE) | ((state == W_HOLD) & ~c_hit);

    assign mem_req   = (state == M_REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = val_q;

endmodule
